// File: rtl/sat_pkg.sv
// Shared SAT-accelerator types: literal encoding and default array sizing.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 127
`endif

package sat_pkg;

  // Signed literal: +v / -v select polarity of variable v, zero means "no literal".
  localparam int LIT_W = $clog2(`LIT_IDX_MAX) + 1;
  typedef logic signed [LIT_W-1:0] lit_t;

  localparam int NUM_PE_DEF    = 4;
  localparam int UCQ_DEPTH_DEF = 8;

  // Complement of a literal (two's complement negate).
  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

endpackage

// File: rtl/ucq_fifo.sv
// Circular literal queue with per-entry valid bits and a parallel probe that
// reports whether a literal or its complement is already queued.
module ucq_fifo
  import sat_pkg::*;
#(
  parameter  int DEPTH = UCQ_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  lit_t          push_lit,
  input  logic          pop,
  input  lit_t          probe,
  output lit_t          head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          hit_same,
  output logic          hit_neg
);

  lit_t             mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;
  lit_t             probe_neg;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign probe_neg = lit_neg(probe);
  assign head      = vld[rd_ptr] ? mem[rd_ptr] : '0;

  // Entry storage write.
  // NOTE: the storage array has no reset; vld qualifies every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_lit;
  end

  // Pointers, occupancy and per-entry valid bits; clr empties the queue.
  // NOTE: non-blocking assignments let every register here sample the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Compare the probe literal and its complement against every live entry.
  always_comb begin
    // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
    hit_same = 1'b0;
    hit_neg  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i] == probe))     hit_same = 1'b1;
      if (vld[i] && (mem[i] == probe_neg)) hit_neg  = 1'b1;
    end
  end

endmodule

// File: rtl/ucq_arb.sv
// Unit-clause queue and arbiter: per-PE skid capture, round-robin drain into
// a dedup/complement-checked queue, and an all-PE-accept broadcast of the head.
module ucq_arb
  import sat_pkg::*;
#(
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int UCQ_DEPTH = UCQ_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_PE-1:0]       pe_imply_valid,
  input  logic [NUM_PE*LIT_W-1:0] pe_imply_lit,
  input  logic [NUM_PE-1:0]       pe_conflict,
  output logic [NUM_PE-1:0]       pe_halt,
  output lit_t                    ucarb2bcp_newLit,
  output logic [NUM_PE-1:0]       ucarb2bcp_newLitValid,
  input  logic [NUM_PE-1:0]       bcp2ucarb_newLitAccept,
  input  lit_t                    dec_lit,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  output logic                    conflict,
  output logic                    ucq_empty
);

  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(UCQ_DEPTH) + 1;

  lit_t              imp_lit  [NUM_PE];
  lit_t              skid_lit [NUM_PE];
  logic [NUM_PE-1:0] skid_valid;
  logic [PW-1:0]     rr_ptr;
  logic [NUM_PE-1:0] acc_mask;

  logic [NUM_PE-1:0] rot;
  logic [PW-1:0]     grant_off;
  logic [SW-1:0]     grant_sum;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     rr_next;
  logic              grant_any;

  lit_t              drain_lit;
  logic              drain;
  logic              drain_nz;
  logic              drain_push;
  logic              cmp_hit;
  logic              dec_push;
  logic              fifo_push;
  lit_t              fifo_push_lit;
  logic              fifo_pop;
  lit_t              fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              hit_same;
  logic              hit_neg;
  logic [NUM_PE-1:0] nlv;
  logic [NUM_PE-1:0] acc_next;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_unpack
    assign imp_lit[g] = lit_t'(pe_imply_lit[g*LIT_W +: LIT_W]);
  end

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    rot       = NUM_PE'({skid_valid, skid_valid} >> rr_ptr);
    grant_any = |skid_valid;
    grant_off = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (rot[k]) grant_off = PW'(k);
    end
    grant_sum = SW'(rr_ptr) + SW'(grant_off);
    grant_idx = (grant_sum >= SW'(NUM_PE)) ? PW'(grant_sum - SW'(NUM_PE)) : PW'(grant_sum);
    rr_next   = (grant_idx == PW'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Drain only when the registered occupancy leaves room; a same-cycle pop does not count.
  assign drain      = grant_any && !conflict && (fifo_count < CW'(UCQ_DEPTH));
  assign drain_lit  = skid_lit[grant_idx];
  assign drain_nz   = drain && (drain_lit != '0);
  assign drain_push = drain_nz && !hit_same && !hit_neg;
  assign cmp_hit    = drain_nz && !hit_same && hit_neg;

  // Decisions enter only when propagation has fully quiesced.
  assign dec_ready     = rst_n && !flush && fifo_empty && !(|skid_valid) && !conflict;
  assign dec_push      = dec_valid && dec_ready;
  assign fifo_push     = drain_push || dec_push;
  assign fifo_push_lit = dec_push ? dec_lit : drain_lit;

  // Broadcast: the head retires once every PE has accepted it, this cycle or earlier.
  assign nlv      = {NUM_PE{!fifo_empty && !conflict}} & ~acc_mask;
  assign acc_next = acc_mask | (nlv & bcp2ucarb_newLitAccept);
  assign fifo_pop = !fifo_empty && !conflict && (&acc_next);

  assign pe_halt               = skid_valid;
  assign ucarb2bcp_newLit      = fifo_head;
  assign ucarb2bcp_newLitValid = nlv;
  assign ucq_empty             = fifo_empty && !(|skid_valid);

  ucq_fifo #(.DEPTH(UCQ_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (fifo_push),
    .push_lit (fifo_push_lit),
    .pop      (fifo_pop),
    .probe    (drain_lit),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .hit_same (hit_same),
    .hit_neg  (hit_neg)
  );

  // Skid literal capture; skid_valid qualifies the contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (pe_imply_valid[i] && !skid_valid[i]) skid_lit[i] <= imp_lit[i];
    end
  end

  // Skid valids, grant pointer, accept mask and sticky conflict; reset and flush clear all.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      skid_valid <= '0;
      rr_ptr     <= '0;
      acc_mask   <= '0;
      conflict   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (drain && (grant_idx == PW'(i)))           skid_valid[i] <= 1'b0;
        else if (pe_imply_valid[i] && !skid_valid[i]) skid_valid[i] <= 1'b1;
      end
      if (drain) rr_ptr <= rr_next;
      acc_mask <= fifo_pop ? '0 : acc_next;
      if ((|pe_conflict) || cmp_hit) conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucq_arb.sv
// Directed bench for ucq_arb: a per-cycle vector table plus hand-written
// sequences for reset, queue-full back-pressure and the decision port.
module tb_ucq_arb;
  import sat_pkg::*;

  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NP-1:0]     pe_imply_valid;
  logic [NP*LIT_W-1:0] pe_imply_lit;
  logic [NP-1:0]     pe_conflict;
  logic [NP-1:0]     pe_halt;
  lit_t              new_lit;
  logic [NP-1:0]     new_lit_valid;
  logic [NP-1:0]     accept;
  lit_t              dec_lit;
  logic              dec_valid;
  logic              dec_ready;
  logic              conflict;
  logic              ucq_empty;
  lit_t              il [NP];

  int n_checks = 0;
  int n_err    = 0;

  assign pe_imply_lit = {il[3], il[2], il[1], il[0]};

  always #5 clk = ~clk;

  ucq_arb #(.NUM_PE(NP), .UCQ_DEPTH(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .flush                  (flush),
    .pe_imply_valid         (pe_imply_valid),
    .pe_imply_lit           (pe_imply_lit),
    .pe_conflict            (pe_conflict),
    .pe_halt                (pe_halt),
    .ucarb2bcp_newLit       (new_lit),
    .ucarb2bcp_newLitValid  (new_lit_valid),
    .bcp2ucarb_newLitAccept (accept),
    .dec_lit                (dec_lit),
    .dec_valid              (dec_valid),
    .dec_ready              (dec_ready),
    .conflict               (conflict),
    .ucq_empty              (ucq_empty)
  );

  typedef struct packed {
    logic       flush;
    logic [3:0] iv;
    lit_t       l0, l1, l2, l3;
    logic [3:0] pc;
    logic [3:0] acc;
    logic       dv;
    lit_t       dl;
    logic [3:0] e_halt;
    logic [3:0] e_nlv;
    lit_t       e_nl;
    logic       e_cf;
    logic       e_emp;
    logic       e_dr;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  function automatic vec_t mk(input logic fl, input logic [3:0] iv, input int l0, input int l1,
                              input int l2, input int l3, input logic [3:0] pc, input logic [3:0] acc,
                              input logic dv, input int dl, input logic [3:0] e_halt,
                              input logic [3:0] e_nlv, input int e_nl, input logic e_cf,
                              input logic e_emp, input logic e_dr);
    vec_t v;
    v        = '0;
    v.flush  = fl;
    v.iv     = iv;
    v.l0     = lit_t'(l0);
    v.l1     = lit_t'(l1);
    v.l2     = lit_t'(l2);
    v.l3     = lit_t'(l3);
    v.pc     = pc;
    v.acc    = acc;
    v.dv     = dv;
    v.dl     = lit_t'(dl);
    v.e_halt = e_halt;
    v.e_nlv  = e_nlv;
    v.e_nl   = lit_t'(e_nl);
    v.e_cf   = e_cf;
    v.e_emp  = e_emp;
    v.e_dr   = e_dr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] h, input logic [3:0] v, input lit_t nl,
                         input logic cf, input logic emp, input logic dr);
    check($sformatf("%s.pe_halt", tag),   32'(pe_halt),        32'(h));
    check($sformatf("%s.newLitValid", tag), 32'(new_lit_valid), 32'(v));
    check($sformatf("%s.newLit", tag),    32'(new_lit),        32'(nl));
    check($sformatf("%s.conflict", tag),  32'(conflict),       32'(cf));
    check($sformatf("%s.ucq_empty", tag), 32'(ucq_empty),      32'(emp));
    check($sformatf("%s.dec_ready", tag), 32'(dec_ready),      32'(dr));
  endtask

  task automatic idle();
    flush          = 1'b0;
    pe_imply_valid = '0;
    pe_conflict    = '0;
    accept         = '0;
    dec_valid      = 1'b0;
    dec_lit        = '0;
    for (int i = 0; i < NP; i++) il[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    flush          = v.flush;
    pe_imply_valid = v.iv;
    il[0]          = v.l0;
    il[1]          = v.l1;
    il[2]          = v.l2;
    il[3]          = v.l3;
    pe_conflict    = v.pc;
    accept         = v.acc;
    dec_valid      = v.dv;
    dec_lit        = v.dl;
  endtask

  initial begin
    // Per-cycle vectors: inputs for the cycle, then outputs expected in that cycle.
    //          fl iv       l0  l1  l2  l3  pc       acc      dv dl   halt     nlv      nl cf emp dr
    vt[0]  = mk(0, 4'b0101,  5,  0,  7,  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    vt[1]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0101, 4'b0000, 0, 0, 0, 0);
    vt[2]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b1010, 0, 0, 4'b0100, 4'b1111, 5, 0, 0, 0);
    vt[3]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0101, 5, 0, 0, 0);
    vt[4]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0100, 0, 0, 4'b0000, 4'b0100, 5, 0, 0, 0);
    vt[5]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 7, 0, 0, 0);
    vt[6]  = mk(0, 4'b0001,  5,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    vt[7]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    vt[8]  = mk(0, 4'b0010,  0,  5,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1111, 5, 0, 0, 0);
    vt[9]  = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b1111, 5, 0, 0, 0);
    vt[10] = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 5, 0, 0, 0);
    vt[11] = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 1, 5, 4'b0000, 4'b0000, 0, 0, 1, 1);
    vt[12] = mk(0, 4'b1000,  0,  0,  0, -5, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1111, 5, 0, 0, 0);
    vt[13] = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b1000, 4'b1111, 5, 0, 0, 0);
    vt[14] = mk(0, 4'b0001,  9,  0,  0,  0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b0000, 5, 1, 0, 0);
    vt[15] = mk(1, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b0000, 5, 1, 0, 0);
    vt[16] = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    vt[17] = mk(1, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 1, 0);
    vt[18] = mk(0, 4'b0010,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    vt[19] = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    vt[20] = mk(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);

    // Reset held two cycles with every PE implying: nothing may be captured.
    idle();
    rst_n          = 1'b0;
    pe_imply_valid = 4'b1111;
    for (int i = 0; i < NP; i++) il[i] = lit_t'(3 + i);
    @(negedge clk);
    chk_out("reset", 4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("release", 4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk_out("post_rel", 4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b1);
    tick();

    // Table: RR drain, staggered accepts, dedup, complement conflict, flush, zero literal.
    for (int r = 0; r < NV; r++) begin
      apply(vt[r]);
      @(negedge clk);
      chk_out($sformatf("vec%0d", r), vt[r].e_halt, vt[r].e_nlv, vt[r].e_nl,
              vt[r].e_cf, vt[r].e_emp, vt[r].e_dr);
      tick();
    end
    idle();

    // Fill the queue to depth with 21..28 through PE0, one implication every other cycle.
    for (int k = 0; k < 8; k++) begin
      pe_imply_valid = 4'b0001;
      il[0]          = lit_t'(21 + k);
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    check("full.head", 32'(new_lit), 32'(lit_t'(21)));
    check("full.nlv", 32'(new_lit_valid), 32'(4'b1111));
    check("full.halt", 32'(pe_halt), 32'(4'b0000));
    tick();
    // A further implication must stay parked in its skid while the queue is full.
    pe_imply_valid = 4'b0010;
    il[1]          = lit_t'(99);
    tick();
    idle();
    @(negedge clk);
    check("full.skid_held0", 32'(pe_halt), 32'(4'b0010));
    tick();
    @(negedge clk);
    check("full.skid_held1", 32'(pe_halt), 32'(4'b0010));
    tick();
    // Pop one: the pop edge itself still sees a full registered count.
    accept = 4'b1111;
    @(negedge clk);
    check("full.skid_at_pop", 32'(pe_halt), 32'(4'b0010));
    tick();
    idle();
    @(negedge clk);
    check("full.skid_after_pop", 32'(pe_halt), 32'(4'b0010));
    check("full.next_head", 32'(new_lit), 32'(lit_t'(22)));
    tick();
    @(negedge clk);
    check("full.drained", 32'(pe_halt), 32'(4'b0000));
    tick();
    // Empty the queue and confirm order 22..28 then 99 (eight entries after the refill).
    for (int j = 0; j < 8; j++) begin
      accept = 4'b1111;
      @(negedge clk);
      check($sformatf("full.pop%0d.lit", j), 32'(new_lit), 32'(lit_t'((j < 7) ? 22 + j : 99)));
      check($sformatf("full.pop%0d.nlv", j), 32'(new_lit_valid), 32'(4'b1111));
      tick();
    end
    idle();
    @(negedge clk);
    check("full.empty", 32'(ucq_empty), 32'(1'b1));
    tick();

    // Decision when quiesced: -3 accepted and broadcast next cycle.
    dec_valid = 1'b1;
    dec_lit   = lit_t'(-3);
    @(negedge clk);
    check("dec.ready_idle", 32'(dec_ready), 32'(1'b1));
    tick();
    idle();
    accept = 4'b1111;
    @(negedge clk);
    check("dec.head", 32'(new_lit), 32'(lit_t'(-3)));
    check("dec.nlv", 32'(new_lit_valid), 32'(4'b1111));
    check("dec.ready_busy", 32'(dec_ready), 32'(1'b0));
    tick();
    idle();
    pe_imply_valid = 4'b0001;
    il[0]          = lit_t'(11);
    @(negedge clk);
    check("dec.empty_again", 32'(ucq_empty), 32'(1'b1));
    tick();
    // With a skid occupied, the decision must be refused.
    idle();
    dec_valid = 1'b1;
    dec_lit   = lit_t'(-3);
    @(negedge clk);
    check("dec.ready_skid", 32'(dec_ready), 32'(1'b0));
    check("dec.halt_skid", 32'(pe_halt), 32'(4'b0001));
    tick();
    accept = 4'b1111;
    @(negedge clk);
    check("dec.head_skid_lit", 32'(new_lit), 32'(lit_t'(11)));
    check("dec.ready_nonempty", 32'(dec_ready), 32'(1'b0));
    tick();
    idle();
    @(negedge clk);
    check("dec.no_stray_push", 32'(ucq_empty), 32'(1'b1));
    check("dec.nlv_off", 32'(new_lit_valid), 32'(4'b0000));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ucq_arb.md
Name: ucq_arb

Overview:
- Unit-clause queue and arbiter sitting directly downstream (implications in) and upstream (new literals out) of the bcp_pe array.
- Captures implications and conflicts from NUM_PE BCP engines, drops duplicates, and detects complementary implications.
- Queues surviving literals and broadcasts each queued literal to every PE. A literal retires only after all PEs accept it.
- Also accepts decision literals when propagation has quiesced.

Parameters:
- NUM_PE, 4, number of bcp_pe instances served.
- UCQ_DEPTH, 8, queue entries; power of two, ≥2.
- LIT_W, from package, literal width: 2's complement, zero reserved as "no literal".

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  clear all state (backtrack); one cycle.
- pe_imply_valid  in  NUM_PE  per-PE implication strobe.
- pe_imply_lit  in  NUM_PE×LIT_W  per-PE implied literal.
- pe_conflict  in  NUM_PE  per-PE clause conflict.
- pe_halt  out  NUM_PE  registered; PE i must hold while set.
- ucarb2bcp_newLit  out  LIT_W  queue head literal, common to all PEs.
- ucarb2bcp_newLitValid  out  NUM_PE  per-PE head-valid.
- bcp2ucarb_newLitAccept  in  NUM_PE  per-PE accept.
- dec_lit  in  LIT_W  decision literal.
- dec_valid  in  1  decision offered.
- dec_ready  out  1  decision accepted this cycle.
- conflict  out  1  sticky conflict flag.
- ucq_empty  out  1  queue empty and no skid entry held.

Behaviour:
- Reset (rst_n=0 at posedge), and flush=1, clear all state:
  - skid_valid, FIFO, accept mask and conflict are cleared.
  - Outputs go to: pe_halt=0, newLitValid=0, newLit=0, conflict=0, ucq_empty=1, dec_ready=0.
  - Priority: reset > flush > everything else.
- Skid stage, one entry per PE:
  - If pe_imply_valid[i] && !skid_valid[i], capture the literal and set skid_valid[i].
  - pe_halt[i] = skid_valid[i] (register output; no combinational path from pe_* inputs to pe_halt).
  - pe_imply_valid[i] while skid_valid[i] is ignored. This is legal only because the PE is halted.
  - A skid holding literal 0 is discarded on drain.
- Drain arbiter:
  - Round-robin over set skid_valid bits; the grant pointer advances past the winner.
  - At most one drain per cycle, and only when FIFO count < UCQ_DEPTH, judged on the registered count. No push-while-full even if a pop occurs the same cycle.
  - The winner's skid is cleared the same cycle.
- Dedup/complement check on the drained literal L, against all valid FIFO entries including the head:
  - Match L → drop, no push.
  - Match −L → set conflict, no push.
  - Otherwise push at tail. L becomes visible at the head 1 cycle after drain if the FIFO was empty.
- Conflict:
  - conflict is set by any pe_conflict bit or by a complement hit.
  - It stays set until flush or reset.
  - While conflict=1: no drains, no pushes, and newLitValid=0. Skids are held, so PEs stay halted.
- Broadcast:
  - newLit = head entry.
  - newLitValid[i] = !empty && !conflict && !acc_mask[i].
  - On newLitValid[i] && newLitAccept[i], set acc_mask[i].
  - When (acc_mask | this-cycle accepts) is all ones: pop head, clear acc_mask. The next head's valid rises the following cycle.
  - A literal re-implied after its pop is re-queued; GST state makes that harmless.
- Decision input:
  - dec_ready = FIFO empty && no skid_valid && !conflict && !flush.
  - On dec_valid && dec_ready, push dec_lit.
  - A skid drain and a decision push never coincide, because dec_ready requires empty skids.
- ucq_empty = FIFO empty && no skid_valid.
- Counts wrap modulo UCQ_DEPTH on pointers. The occupancy counter is $clog2(UCQ_DEPTH)+1 bits.

Decomposition:
- Shared package sat_pkg holds:
  - LIT_W = $clog2(`LIT_IDX_MAX)+1 and lit_t (signed [LIT_W-1:0]).
  - NUM_PE and UCQ_DEPTH defaults.
  - A lit_neg function (2's complement negate).
- One sub-module: ucq_fifo.
  - Circular buffer with push/pop/count.
  - Per-entry valid, plus two match outputs (hit_same, hit_neg) for a probe literal.
- Round-robin arbiter and skids stay in ucq_arb.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while pe_imply_valid=4'b1111 → all outputs 0, ucq_empty=1; after release, nothing captured from those cycles.
2. PE0 implies +5, PE2 implies +7 in the same cycle → pe_halt=0101 next cycle; drains in RR order +5 then +7 on consecutive cycles; head +5 with newLitValid=1111.
3. Head +5; accept from PEs 1, 3, then 0, 2 in later cycles → newLitValid bits drop individually; pop only in the cycle the last accept arrives; +7 valid next cycle.
4. Queue holds +5; PE1 implies +5 → dropped, count unchanged. PE3 implies −5 → conflict=1, newLitValid=0; flush → conflict=0, ucq_empty=1.
5. Fill to UCQ_DEPTH=8 with distinct literals; further implication → held in skid, pe_halt=1; one pop → drain next cycle, count back to 8.
6. Queue empty, dec_valid with dec_lit=−3 → dec_ready=1, −3 broadcast next cycle. With a skid occupied → dec_ready=0.
